// File: rtl/laser_shot_arbiter.sv
// Round-robin arbiter that shares one laser and its countdown timer among NREQ requesters.
// A granted shot arms the timer, fires until Z or Abort, then holds off for COOL cycles.
module laser_shot_arbiter #(
    parameter int NREQ = 4,
    parameter int COOL = 10,
    parameter int CW   = 8
) (
    input  logic            Clk,
    input  logic            Rst_n,
    input  logic [NREQ-1:0] Req,
    input  logic            Abort,
    input  logic            Z,
    output logic            Ec,
    output logic            Rc,
    output logic            X,
    output logic [NREQ-1:0] Grant,
    output logic            Done,
    output logic            Aborted,
    output logic            Busy
);

    localparam int PW = (NREQ > 2) ? $clog2(NREQ) : 1;
    localparam logic [NREQ-1:0] ONE = 1;

    typedef enum logic [1:0] {
        SIdle = 2'd0,
        SArm  = 2'd1,
        SOn   = 2'd2,
        SCool = 2'd3
    } state_t;

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   owner;
    logic [PW-1:0]   next_ptr;
    logic [CW-1:0]   cnt;
    logic            found;
    logic [PW-1:0]   win;
    int              j;

    // First requesting index at or above the pointer, wrapping modulo NREQ.
    always_comb begin
        found = 1'b0;
        win   = '0;
        j     = 0;
        for (int i = 0; i < NREQ; i++) begin
            j = int'(ptr) + i;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!found && Req[j[PW-1:0]]) begin
                found = 1'b1;
                win   = j[PW-1:0];
            end
        end
    end

    assign next_ptr = (owner == PW'(NREQ - 1)) ? '0 : owner + 1'b1;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state   <= SIdle;
            ptr     <= '0;
            owner   <= '0;
            cnt     <= '0;
            Ec      <= 1'b0;
            Rc      <= 1'b0;
            X       <= 1'b0;
            Grant   <= '0;
            Done    <= 1'b0;
            Aborted <= 1'b0;
            Busy    <= 1'b0;
        end else begin
            Done    <= 1'b0;
            Aborted <= 1'b0;
            case (state)
                SIdle: begin
                    Ec <= 1'b0;
                    X  <= 1'b0;
                    if (found) begin
                        owner <= win;
                        Grant <= ONE << win;
                        Rc    <= 1'b1;
                        Busy  <= 1'b1;
                        state <= SArm;
                    end else begin
                        Rc    <= 1'b0;
                        Grant <= '0;
                        Busy  <= 1'b0;
                    end
                end
                SArm: begin
                    Rc    <= 1'b0;
                    Ec    <= 1'b1;
                    X     <= 1'b1;
                    state <= SOn;
                end
                SOn: begin
                    // Abort takes priority over Z when both arrive together.
                    if (Abort || Z) begin
                        Ec      <= 1'b0;
                        X       <= 1'b0;
                        Grant   <= '0;
                        Done    <= 1'b1;
                        Aborted <= Abort;
                        ptr     <= next_ptr;
                        cnt     <= CW'(COOL - 1);
                        state   <= SCool;
                    end
                end
                SCool: begin
                    if (cnt == '0) begin
                        Busy  <= 1'b0;
                        state <= SIdle;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    Ec    <= 1'b0;
                    Rc    <= 1'b0;
                    X     <= 1'b0;
                    Grant <= '0;
                    Busy  <= 1'b0;
                    state <= SIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_laser_shot_arbiter.sv
// Bench for laser_shot_arbiter: shot-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_laser_shot_arbiter;

    localparam int NREQ = 4;
    localparam int COOL = 10;
    localparam int CW   = 8;
    localparam int PW   = $clog2(NREQ);
    localparam int OW   = NREQ + 6;

    logic            Clk = 1'b0;
    logic            Rst_n = 1'b1;
    logic [NREQ-1:0] Req = '0;
    logic            Abort = 1'b0;
    logic            Z = 1'b0;
    logic            Ec, Rc, X, Done, Aborted, Busy;
    logic [NREQ-1:0] Grant;

    int tests_run = 0;
    int tests_failed = 0;
    bit compare_en = 1'b0;

    // Reference model: who owns the shot, where it is in its life, and cool-down remaining.
    int m_owner = -1;
    int m_ptr = 0;
    int m_cool = 0;
    bit m_arm = 1'b0;
    bit m_fire = 1'b0;
    bit m_done = 1'b0;
    bit m_abt = 1'b0;

    int cnt_x, cnt_rc, cnt_done, cnt_abt, cnt_cool;

    laser_shot_arbiter #(.NREQ(NREQ), .COOL(COOL), .CW(CW)) dut (
        .Clk(Clk),
        .Rst_n(Rst_n),
        .Req(Req),
        .Abort(Abort),
        .Z(Z),
        .Ec(Ec),
        .Rc(Rc),
        .X(X),
        .Grant(Grant),
        .Done(Done),
        .Aborted(Aborted),
        .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    task automatic model_step();
        int c;
        bit hit;
        m_done = 1'b0;
        m_abt  = 1'b0;
        if (m_arm) begin
            m_arm  = 1'b0;
            m_fire = 1'b1;
        end else if (m_fire) begin
            if (Abort || Z) begin
                m_fire  = 1'b0;
                m_done  = 1'b1;
                m_abt   = Abort;
                m_ptr   = (m_owner + 1) % NREQ;
                m_owner = -1;
                m_cool  = COOL;
            end
        end else if (m_cool > 0) begin
            m_cool = m_cool - 1;
        end else if (Req != '0) begin
            hit = 1'b0;
            for (int k = 0; k < NREQ; k++) begin
                c = (m_ptr + k) % NREQ;
                if (!hit && Req[c[PW-1:0]]) begin
                    hit     = 1'b1;
                    m_owner = c;
                end
            end
            m_arm = 1'b1;
        end
    endtask

    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            m_owner = -1;
            m_ptr   = 0;
            m_cool  = 0;
            m_arm   = 1'b0;
            m_fire  = 1'b0;
            m_done  = 1'b0;
            m_abt   = 1'b0;
        end else begin
            model_step();
        end
    end

    function automatic logic [OW-1:0] model_outputs();
        logic [NREQ-1:0] g;
        g = '0;
        if (m_owner >= 0) g = NREQ'(1) << m_owner;
        return {m_fire, m_arm, m_fire, g, m_done, m_abt, (m_arm || m_fire || m_cool > 0)};
    endfunction

    function automatic logic [OW-1:0] dut_outputs();
        return {Ec, Rc, X, Grant, Done, Aborted, Busy};
    endfunction

    always @(negedge Clk) begin
        if (compare_en) begin
            tests_run++;
            if (dut_outputs() !== model_outputs()) begin
                tests_failed++;
                $display("[TB] FAIL cycle_outputs t=%0t got %b expected %b (Ec,Rc,X,Grant,Done,Aborted,Busy)",
                         $time, dut_outputs(), model_outputs());
            end
            if (X) cnt_x++;
            if (Rc) cnt_rc++;
            if (Done) cnt_done++;
            if (Aborted) cnt_abt++;
            if (Busy && !X && !Rc) cnt_cool++;
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic clear_counters();
        cnt_x = 0; cnt_rc = 0; cnt_done = 0; cnt_abt = 0; cnt_cool = 0;
    endtask

    task automatic apply_reset();
        @(negedge Clk);
        #2 Rst_n = 1'b0;
        #1 check_output("reset_async", 32'(dut_outputs()), 32'd0);
        @(negedge Clk);
        compare_en = 1'b1;
        #2 Rst_n = 1'b1;
    endtask

    task automatic wait_arm(input string name, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 60 && !ok; n++) begin
            @(negedge Clk);
            if (m_arm) ok = 1'b1;
        end
        if (!ok) check_output({name, "_arm_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 60 && !ok; n++) begin
            @(negedge Clk);
            if (!m_arm && !m_fire && m_cool == 0) ok = 1'b1;
        end
        if (!ok) check_output({name, "_idle_timeout"}, 32'd0, 32'd1);
    endtask

    // One shot: request, check the grant, then end it with Z or with Abort+Z.
    task automatic run_shot(input logic [NREQ-1:0] r, input int on_cycles, input bit hold_req,
                            input int abort_at, input logic [NREQ-1:0] exp_grant, input string name);
        bit ok;
        int n;
        Req = r;
        wait_arm(name, ok);
        if (!ok) return;
        check_output(name, 32'(Grant), 32'(exp_grant));
        if (!hold_req) Req = '0;
        n = (abort_at > 0) ? abort_at : on_cycles;
        repeat (n) @(negedge Clk);
        Z = 1'b1;
        Abort = (abort_at > 0);
        @(negedge Clk);
        Z = 1'b0;
        Abort = 1'b0;
    endtask

    task automatic apply_stimulus(input int cycles);
        for (int n = 0; n < cycles; n++) begin
            @(negedge Clk);
            Req   = NREQ'($urandom_range(0, (1 << NREQ) - 1));
            Abort = ($urandom_range(0, 7) == 0);
            Z     = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 199) == 0) begin
                #2 Rst_n = 1'b0;
                @(negedge Clk);
                #2 Rst_n = 1'b1;
            end
        end
        @(negedge Clk);
        Req = '0; Abort = 1'b0; Z = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [NREQ-1:0] order4 [5];
        logic [NREQ-1:0] order5 [3];
        bit ok;
        order4 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        order5 = '{4'b0100, 4'b0001, 4'b0100};

        apply_reset();
        @(negedge Clk);
        check_output("reset_release", 32'(dut_outputs()), 32'd0);

        clear_counters();
        run_shot(4'b0001, 5, 1'b0, 0, 4'b0001, "single_grant");
        wait_idle("single");
        check_output("single_x_cycles", 32'(cnt_x), 32'd5);
        check_output("single_rc_cycles", 32'(cnt_rc), 32'd1);
        check_output("single_done", 32'(cnt_done), 32'd1);
        check_output("single_aborted", 32'(cnt_abt), 32'd0);
        check_output("single_cool", 32'(cnt_cool), 32'(COOL));
        check_output("single_busy_low", 32'(Busy), 32'd0);

        apply_reset();
        clear_counters();
        foreach (order4[i]) run_shot(4'b1111, 3, 1'b1, 0, order4[i], $sformatf("rr_all_%0d", i));
        Req = '0;
        wait_idle("rr_all");
        check_output("rr_all_done", 32'(cnt_done), 32'd5);
        check_output("rr_all_x", 32'(cnt_x), 32'd15);

        foreach (order5[i]) run_shot(4'b0101, 2, 1'b1, 0, order5[i], $sformatf("rr_pair_%0d", i));
        Req = '0;
        wait_idle("rr_pair");

        clear_counters();
        run_shot(4'b0010, 5, 1'b0, 2, 4'b0010, "abort_grant");
        wait_idle("abort");
        check_output("abort_x_cycles", 32'(cnt_x), 32'd2);
        check_output("abort_done", 32'(cnt_done), 32'd1);
        check_output("abort_aborted", 32'(cnt_abt), 32'd1);
        check_output("abort_cool", 32'(cnt_cool), 32'(COOL));

        clear_counters();
        Req = 4'b0001;
        wait_arm("midreset", ok);
        Req = '0;
        repeat (2) @(negedge Clk);
        check_output("midreset_x_before", 32'(X), 32'd1);
        #2 Rst_n = 1'b0;
        #1 check_output("midreset_async", 32'({X, Ec, Grant}), 32'd0);
        @(negedge Clk);
        check_output("midreset_no_done", 32'(cnt_done), 32'd0);
        Req = 4'b1000;
        #2 Rst_n = 1'b1;
        run_shot(4'b1000, 2, 1'b0, 0, 4'b1000, "midreset_regrant");
        wait_idle("midreset");

        run_shot(4'b0001, 3, 1'b0, 0, 4'b0001, "coolreq_grant");
        clear_counters();
        repeat (2) @(negedge Clk);
        Req = 4'b0010;
        repeat (4) @(negedge Clk);
        Req = '0;
        repeat (20) @(negedge Clk);
        check_output("coolreq_no_arm", 32'(cnt_rc), 32'd0);
        check_output("coolreq_busy_low", 32'(Busy), 32'd0);
        check_output("coolreq_grant_low", 32'(Grant), 32'd0);

        apply_stimulus(3000);
        wait_idle("random");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
